// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator side of a 4-bit combinational ALU.
// - Accepts one command (opcode + operands) over a valid/ready handshake.
// - Holds the operands in registers so the ALU only ever sees stable inputs.
// - Waits one cycle for the ALU to settle, captures the result and flags.
// - Returns them as a response over a second valid/ready handshake.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   cmd_valid      command present
//   cmd_ready      sequencer idle and able to take a command
//   cmd_sel        ALU opcode:
//                    000 add, 001 sub, 010 not A, 011 and,
//                    100 or,  101 xor, 110 signed less-than, 111 equal
//   cmd_a / cmd_b  operands
//   cmd_chain      (only with ALU_SEQ_CHAIN_EN) take A from the previous result
//   alu_sel        registered opcode to the ALU
//   alu_a / alu_b  registered operands to the ALU
//   alu_result     ALU result
//   alu_overflow   ALU overflow flag
//   alu_carry      ALU carry flag
//   rsp_valid      response present
//   rsp_ready      consumer accepts the response
//   rsp_result     captured result
//   rsp_zero       captured result == 0
//   rsp_overflow   captured overflow, add/sub only
//   rsp_carry      captured carry, add/sub only
//   op_count       number of responses consumed (wraps)
//
// Build option
//   ALU_SEQ_CHAIN_EN : adds cmd_chain. When cmd_chain is set on accept,
//                      operand A is taken from the last captured rsp_result.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [2:0]       alu_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_capture;
    logic              w_consume;
    logic              w_arith;
    logic [3:0]        w_a_load;

    logic [2:0]        r_alu_sel;
    logic [3:0]        r_alu_a;
    logic [3:0]        r_alu_b;
    logic              r_rsp_valid;
    logic [3:0]        r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_overflow;
    logic              r_rsp_carry;
    logic [CNT_W-1:0]  r_op_count;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable for a full cycle; sample the ALU.
                w_capture    = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_consume    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ready depends on state only, so upstream can never form a loop through it.
    assign cmd_ready = (r_state == ST_IDLE);

    // Overflow and carry are only meaningful for add (000) and sub (001).
    assign w_arith = (r_alu_sel == 3'b000) || (r_alu_sel == 3'b001);

`ifdef ALU_SEQ_CHAIN_EN
    assign w_a_load = cmd_chain ? r_rsp_result : cmd_a;
`else
    assign w_a_load = cmd_a;
`endif

    // ------------------------------------------------------------------
    // Operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_sel <= 3'd0;
            r_alu_a   <= 4'd0;
            r_alu_b   <= 4'd0;
        end else if (w_accept) begin
            r_alu_sel <= cmd_sel;
            r_alu_a   <= w_a_load;
            r_alu_b   <= cmd_b;
        end
    end

    // ------------------------------------------------------------------
    // Response registers. Payload is left in place after the handshake
    // and only overwritten by the next capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= 4'd0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_carry    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_result   <= alu_result;
            r_rsp_zero     <= (alu_result == 4'd0);
            r_rsp_overflow <= alu_overflow & w_arith;
            r_rsp_carry    <= alu_carry & w_arith;
        end else if (w_consume) begin
            r_rsp_valid    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Completed-operation counter, counts consumed responses only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_consume) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign alu_sel      = r_alu_sel;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_carry    = r_rsp_carry;
    assign op_count     = r_op_count;

endmodule
